// File: rtl/deal_arbiter.sv
// Two-requester card-deal arbiter: round-robin grant, one LUT draw per grant, deck count tracking.
// Optional `DEAL_RANK_LIMIT_EN: caps each rank at four deliveries per game, redrawing on a fifth.
module deal_arbiter #(
  parameter int TIMEOUT   = 15,
  parameter int DECK_SIZE = 52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       new_game,
  input  logic [3:0] number,
  output logic       pip,
  output logic [1:0] gnt,
  output logic [3:0] card,
  output logic       card_vld,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic       timeout_err
);

  localparam int WCW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DELIVER} state_t;

  state_t         state, state_n;
  logic [WCW-1:0] wait_cnt;
  logic [3:0]     card_q;
  logic           owner;
  logic           rr_last;   // owner of the most recent grant; 1 after reset so player wins ties
  logic           win;
  logic           num_ok;
  logic           tmo;

`ifdef DEAL_RANK_LIMIT_EN
  logic [12:0][2:0] rank_cnt;
  logic [3:0]       rank_idx;
  assign rank_idx = card_q - 4'd1;
`endif

  assign num_ok = (number >= 4'd1) && (number <= 4'd13);

  always_comb begin
    win = 1'b0;
    unique case (req)
      2'b10:   win = 1'b1;
      2'b11:   win = ~rr_last;
      default: win = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    tmo     = 1'b0;
    case (state)
      IDLE:    if (req != 2'b00 && !deck_empty) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT: begin
        if (num_ok) state_n = CHECK;
        else if (wait_cnt == WCW'(TIMEOUT)) begin
          state_n = IDLE;
          tmo     = 1'b1;
        end
      end
`ifdef DEAL_RANK_LIMIT_EN
      CHECK:   state_n = (rank_cnt[rank_idx] == 3'd4) ? ISSUE : DELIVER;
`else
      CHECK:   state_n = DELIVER;
`endif
      DELIVER: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (new_game) begin
      state_n = IDLE;
      tmo     = 1'b0;
    end
  end

  // Outputs are flops loaded from the next-state decode so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      pip         <= 1'b0;
      gnt         <= 2'b00;
      card        <= 4'd0;
      card_vld    <= 1'b0;
      busy        <= 1'b0;
      cards_left  <= 6'(DECK_SIZE);
      deck_empty  <= (DECK_SIZE == 0);
      timeout_err <= 1'b0;
      rr_last     <= 1'b1;
      wait_cnt    <= '0;
      owner       <= 1'b0;
      card_q      <= 4'd0;
`ifdef DEAL_RANK_LIMIT_EN
      rank_cnt    <= '0;
`endif
    end else begin
      pip      <= (state_n == ISSUE);
      busy     <= (state_n != IDLE);
      card_vld <= (state_n == DELIVER);
      gnt      <= (state_n == DELIVER) ? (owner ? 2'b10 : 2'b01) : 2'b00;
      card     <= (state_n == DELIVER) ? card_q : 4'd0;

      if (state == IDLE && state_n == ISSUE) owner <= win;

      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + WCW'(1);

      if (state == WAIT && num_ok) card_q <= number;
      if (tmo) timeout_err <= 1'b1;

      if (state_n == DELIVER) begin
        if (cards_left != 6'd0) cards_left <= cards_left - 6'd1;
        deck_empty <= (cards_left <= 6'd1);
        rr_last    <= owner;
      end

`ifdef DEAL_RANK_LIMIT_EN
      if (state == CHECK && state_n == DELIVER)
        rank_cnt[rank_idx] <= rank_cnt[rank_idx] + 3'd1;
`endif
    end
  end

endmodule

// File: tb/tb_deal_arbiter.sv
// Directed bench for deal_arbiter: LUT-dealer responder, scoreboard queue of expected deliveries.
module tb_deal_arbiter;

  logic       clk = 1'b0;
  logic       rst, new_game;
  logic [1:0] req;
  logic [3:0] number;
  logic       pip, card_vld, busy, deck_empty, timeout_err;
  logic [1:0] gnt;
  logic [3:0] card;
  logic [5:0] cards_left;

  typedef struct packed {logic [1:0] g; logic [3:0] c;} exp_t;

  exp_t       exp_q[$];
  logic [3:0] dealer_q[$];
  int         checks = 0;
  int         errors = 0;
  int         pip_cnt = 0;

  deal_arbiter #(.TIMEOUT(15), .DECK_SIZE(52)) dut (
    .clk(clk), .rst(rst), .req(req), .new_game(new_game), .number(number),
    .pip(pip), .gnt(gnt), .card(card), .card_vld(card_vld), .busy(busy),
    .cards_left(cards_left), .deck_empty(deck_empty), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // LUT dealer: answers each pip with the next queued value, held across the WAIT sample edge.
  initial begin
    int hold = 0;
    number = 4'd0;
    forever begin
      @(negedge clk);
      if (hold > 0) begin
        hold--;
        if (hold == 0) number = 4'd0;
      end
      if (pip) begin
        pip_cnt++;
        if (dealer_q.size() > 0) begin
          number = dealer_q.pop_front();
          hold   = 2;
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (card_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL delivery: unexpected card_vld gnt=%b card=%0d", gnt, card);
        end else begin
          e = exp_q.pop_front();
          if (gnt !== e.g || card !== e.c) begin
            errors++;
            $display("FAIL delivery: got gnt=%b card=%0d, expected gnt=%b card=%0d", gnt, card, e.g, e.c);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  // One draw: request held until a grant appears, bounded.
  task automatic draw(input logic [1:0] r, input logic [3:0] v, input logic [1:0] eg);
    int n = 0;
    dealer_q.push_back(v);
    exp_q.push_back({eg, v});
    req = r;
    while (gnt == 2'b00 && n < 30) begin
      tick();
      n++;
    end
    if (gnt == 2'b00) chk("draw_timeout", 0, 1);
    req = 2'b00;
    tick();
  endtask

  initial begin
    int p0, n, t0;
    rst = 1'b1; new_game = 1'b0; req = 2'b00;
    repeat (3) tick();
    chk("rst_pip", pip, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_card", card, 0);
    chk("rst_card_vld", card_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cards_left", cards_left, 52);
    chk("rst_deck_empty", deck_empty, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    tick();

    // Minimum latency single draw
    dealer_q.push_back(4'd7);
    exp_q.push_back({2'b01, 4'd7});
    req = 2'b01;
    tick(); chk("lat_pip_c1", pip, 1); chk("lat_busy_c1", busy, 1);
    tick(); chk("lat_pip_c2", pip, 0);
    tick(); chk("lat_vld_c3", card_vld, 0);
    tick(); chk("lat_vld_c4", card_vld, 1); chk("lat_gnt_c4", gnt, 1); chk("lat_card_c4", card, 7);
    req = 2'b00;
    tick(); chk("lat_cards_left", cards_left, 51); chk("lat_vld_c5", card_vld, 0);

    // Round-robin with both requesting
    pulse_new_game();
    chk("ng_cards_left", cards_left, 52);
    p0 = pip_cnt;
    dealer_q.push_back(4'd2); exp_q.push_back({2'b01, 4'd2});
    dealer_q.push_back(4'd3); exp_q.push_back({2'b10, 4'd3});
    dealer_q.push_back(4'd4); exp_q.push_back({2'b01, 4'd4});
    dealer_q.push_back(4'd5); exp_q.push_back({2'b10, 4'd5});
    req = 2'b11;
    n = 0; t0 = 0;
    while (n < 4 && t0 < 100) begin
      tick(); t0++;
      if (gnt != 2'b00) n++;
    end
    req = 2'b00;
    tick();
    chk("rr_grants", n, 4);
    chk("rr_pips", pip_cnt - p0, 4);
    chk("rr_cards_left", cards_left, 48);

    // Dealer never answers: timeout
    pulse_new_game();
    p0 = pip_cnt;
    req = 2'b01;
    n = 0;
    while (!pip && n < 10) begin tick(); n++; end
    chk("tmo_pip_seen", pip, 1);
    t0 = 0;
    while (!timeout_err && t0 < 40) begin tick(); t0++; end
    req = 2'b00;
    chk("tmo_err", timeout_err, 1);
    checks++;
    if (t0 < 15 || t0 > 17) begin
      errors++;
      $display("FAIL tmo_latency: got %0d cycles, expected 15..17", t0);
    end
    tick();
    chk("tmo_busy", busy, 0);
    chk("tmo_cards_left", cards_left, 52);
    chk("tmo_pips", pip_cnt - p0, 1);
    tick();
    chk("tmo_sticky", timeout_err, 1);
    pulse_new_game();
    chk("tmo_cleared", timeout_err, 0);

    // Exhaust the deck (each rank exactly four times)
    for (int i = 0; i < 52; i++) draw(2'b01, 4'((i % 13) + 1), 2'b01);
    chk("deck_cards_left", cards_left, 0);
    chk("deck_empty", deck_empty, 1);
    p0 = pip_cnt;
    req = 2'b01;
    repeat (20) tick();
    req = 2'b00;
    chk("deck_no_pip", pip_cnt - p0, 0);
    chk("deck_still_0", cards_left, 0);
    chk("deck_busy", busy, 0);

`ifdef DEAL_RANK_LIMIT_EN
    pulse_new_game();
    for (int i = 0; i < 4; i++) draw(2'b01, 4'd5, 2'b01);
    p0 = pip_cnt;
    dealer_q.push_back(4'd5);
    draw(2'b01, 4'd9, 2'b01);
    chk("rank_redraw_pips", pip_cnt - p0, 2);
    chk("rank_cards_left", cards_left, 47);
`endif

    // new_game during WAIT
    pulse_new_game();
    draw(2'b10, 4'd11, 2'b10);
    chk("abort_pre_cards", cards_left, 51);
    req = 2'b01;
    n = 0;
    while (!pip && n < 10) begin tick(); n++; end
    tick();
    new_game = 1'b1;
    req = 2'b00;
    tick();
    new_game = 1'b0;
    chk("ng_abort_busy", busy, 0);
    chk("ng_abort_pip", pip, 0);
    chk("ng_abort_cards", cards_left, 52);
    p0 = 0;
    repeat (20) begin tick(); if (gnt != 2'b00 || pip) p0++; end
    chk("ng_abort_quiet", p0, 0);

    // rst during ISSUE
    draw(2'b01, 4'd13, 2'b01);
    req = 2'b01;
    n = 0;
    while (!pip && n < 10) begin tick(); n++; end
    chk("rst_issue_pip", pip, 1);
    rst = 1'b1;
    req = 2'b00;
    tick();
    chk("rst_abort_pip", pip, 0);
    chk("rst_abort_gnt", gnt, 0);
    chk("rst_abort_busy", busy, 0);
    chk("rst_abort_cards", cards_left, 52);
    rst = 1'b0;
    p0 = 0;
    repeat (20) begin tick(); if (gnt != 2'b00 || pip) p0++; end
    chk("rst_abort_quiet", p0, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/deal_arbiter.md
DEAL_ARBITER -- requirements
Module: deal_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: WAIT-state cycle limit before abort.
REQ-002 SHALL have parameter DECK_SIZE, default 52: cards available per game.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  2  level draw request; bit0 player, bit1 dealer; held until gnt.
REQ-006 SHALL have port new_game  input  1  one-cycle pulse restoring a full deck.
REQ-007 SHALL have port number  input  4  card value returned by the LUT dealer; 1..13 valid, other values ignored.
REQ-008 SHALL have port pip  output  1  one-cycle draw strobe to the LUT dealer.
REQ-009 SHALL have port gnt  output  2  one-hot one-cycle grant, coincident with card_vld.
REQ-010 SHALL have port card  output  4  delivered card value, valid with card_vld.
REQ-011 SHALL have port card_vld  output  1  one-cycle card-delivered pulse.
REQ-012 SHALL have port busy  output  1  high from ISSUE through DELIVER.
REQ-013 SHALL have port cards_left  output  6  remaining deck count.
REQ-014 SHALL have port deck_empty  output  1  high when cards_left == 0.
REQ-015 SHALL have port timeout_err  output  1  sticky; set on WAIT timeout, cleared by rst or new_game.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, CHECK, DELIVER; registered outputs only.
REQ-017 IDLE: if req != 0 and !deck_empty, SHALL latch the owner and go to ISSUE next cycle; otherwise SHALL stay in IDLE, with pip low.
REQ-018 Arbitration SHALL be round-robin: single request wins; if both request, the one not granted last wins; after reset/new_game, player (bit0) wins ties.
REQ-019 ISSUE: pip SHALL be 1 for exactly this cycle; the wait counter SHALL clear; next state WAIT.
REQ-020 WAIT: number SHALL be sampled every cycle, and a value of 1..13 SHALL capture the card and move to CHECK.
REQ-021 WAIT: when the wait counter reaches TIMEOUT, the block SHALL set timeout_err, return to IDLE, and issue no gnt; the round-robin pointer SHALL be unchanged.
REQ-022 CHECK: the card SHALL be accepted, and the block SHALL go to DELIVER (rank check per REQ-033).
REQ-023 DELIVER: card_vld=1, gnt[owner]=1, card=captured value for one cycle; cards_left SHALL decrement; round-robin pointer SHALL update; next state IDLE.
REQ-024 Minimum latency: req in IDLE at cycle 0 -> pip cycle 1 -> number valid cycle 2 -> CHECK cycle 3 -> card_vld cycle 4.
REQ-025 If req drops after the owner is latched, the transaction SHALL still complete, and the card SHALL be delivered to the latched owner.
REQ-026 Back-to-back: a held request SHALL re-enter ISSUE no earlier than the cycle after DELIVER, with one card per grant.
REQ-027 new_game SHALL take priority over all states except rst, aborting any transaction without gnt: pip=0, cards_left=DECK_SIZE, rank counts=0, timeout_err=0, pointer to player, and state=IDLE.
REQ-028 Requests SHALL be ignored while deck_empty; cards_left SHALL never wrap below 0.

Reset
REQ-029 With rst high at a clk edge, the FSM SHALL go to IDLE, with pip=0, gnt=0, card=0, card_vld=0, busy=0, and timeout_err=0.
REQ-030 Reset SHALL also set cards_left=DECK_SIZE, deck_empty=0, rank counts=0, wait counter=0, and the pointer to player.
REQ-031 rst mid-transaction SHALL abort, with no pip or gnt in the following cycle.
REQ-032 rst SHALL take priority over new_game and all requests.

Configuration
REQ-033 With macro DEAL_RANK_LIMIT_EN defined, the block SHALL keep 13 three-bit rank counters; in CHECK, rank count == 4 SHALL return to ISSUE (redraw, same owner, no cards_left change), and otherwise the count SHALL increment before DELIVER.
REQ-034 Without DEAL_RANK_LIMIT_EN, the rank counters SHALL be absent, and CHECK SHALL always proceed to DELIVER; all other behaviour SHALL be identical.

Verification
REQ-035 Bench SHALL apply req=01 with number=7 one cycle after pip -> pip at cycle 1, card_vld/gnt=01/card=7 at cycle 4, cards_left 52->51.
REQ-036 Bench SHALL hold req=11 for 4 draws -> gnt sequence 01,10,01,10 with exactly one pip per grant.
REQ-037 Bench SHALL keep number=0 after pip, with TIMEOUT=15 -> return to IDLE, timeout_err=1, no gnt, and cards_left unchanged; new_game then clears timeout_err.
REQ-038 Bench SHALL draw 52 cards, then assert req=01 -> deck_empty=1, no further pip, cards_left stays 0.
REQ-039 Bench SHALL, with DEAL_RANK_LIMIT_EN, return number=5 five times -> 4 deliveries, and the fifth CHECK SHALL cause a redraw pip; returning number=9 SHALL deliver card=9.
REQ-040 Bench SHALL pulse new_game in WAIT, and separately rst in ISSUE -> no gnt, state IDLE, cards_left=52.
